// File: rtl/acq_buf_ctrl_pkg.sv
// Shared types for the ADC capture buffer controller: FSM state encoding
// (also reported through the localbus status register) and small helpers.
package acqbuf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    WAIT    = 2'd3
  } acq_state_t;

  localparam logic [1:0] ACQ_STATUS_IDLE    = 2'd0;
  localparam logic [1:0] ACQ_STATUS_ARMED   = 2'd1;
  localparam logic [1:0] ACQ_STATUS_CAPTURE = 2'd2;
  localparam logic [1:0] ACQ_STATUS_WAIT    = 2'd3;

  // Lowest-index free buffer; falls back to buffer 0 when both are full.
  function automatic logic lowest_free(input logic [1:0] full);
    logic sel;
    if (!full[0]) begin
      sel = 1'b0;
    end else if (!full[1]) begin
      sel = 1'b1;
    end else begin
      sel = 1'b0;
    end
    return sel;
  endfunction

endpackage

// File: rtl/acq_buf_ctrl_decim.sv
// Valid-beat modulo counter: keeps one of every (decim+1) valid beats,
// restarting the phase on clear so the first beat after a trigger is kept.
module acq_decim
  import acqbuf_pkg::*;
#(
  parameter int DECIM_WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clr,
  input  logic                   i_valid,
  input  logic [DECIM_WIDTH-1:0] i_decim,
  output logic                   o_keep
);

  logic [DECIM_WIDTH-1:0] r_cnt;

  // The >= wrap also recovers if decim is re-latched below the running count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= {DECIM_WIDTH{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {DECIM_WIDTH{1'b0}};
    end else if (i_valid) begin
      if (r_cnt >= i_decim) begin
        r_cnt <= {DECIM_WIDTH{1'b0}};
      end else begin
        r_cnt <= r_cnt + {{(DECIM_WIDTH-1){1'b0}}, 1'b1};
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_keep = i_valid & (r_cnt == {DECIM_WIDTH{1'b0}});

endmodule

// File: rtl/acq_buf_ctrl.sv
// Ping-pong capture sequencer: steers decimated ADC stream beats into two
// PS-readable BRAMs under arm/trigger/abort control, counting dropped beats.
module acq_buf_ctrl
  import acqbuf_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 13,
  parameter int DECIM_WIDTH = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_arm,
  input  logic                   i_trig,
  input  logic                   i_abort,
  input  logic                   i_cont,
  input  logic [ADDR_WIDTH-1:0]  i_len,
  input  logic [DECIM_WIDTH-1:0] i_decim,
  input  logic [1:0]             i_buf_release,
  input  logic                   i_s_valid,
  input  logic [DATA_WIDTH-1:0]  i_s_data,
  output logic                   o_s_ready,
  output logic [1:0]             o_bram_we,
  output logic [ADDR_WIDTH-1:0]  o_bram_addr,
  output logic [DATA_WIDTH-1:0]  o_bram_din,
  output logic [1:0]             o_buf_full,
  output logic                   o_active_buf,
  output logic                   o_busy,
  output logic                   o_overflow,
  output logic [CNT_WIDTH-1:0]   o_drop_cnt
);

  acq_state_t             r_state;
  acq_state_t             w_state_nxt;
  logic                   r_active, w_active_nxt;
  logic [ADDR_WIDTH-1:0]  r_addr, w_addr_nxt;
  logic [1:0]             r_full, w_full_nxt;
  logic [1:0]             w_we_nxt;
  logic [ADDR_WIDTH-1:0]  r_len;
  logic [DECIM_WIDTH-1:0] r_decim;
  logic                   r_cont;
  logic                   w_latch, w_clr, w_drop, w_keep;
  logic                   r_ready, r_busy, r_overflow;
  logic [1:0]             r_we;
  logic [ADDR_WIDTH-1:0]  r_wr_addr;
  logic [DATA_WIDTH-1:0]  r_din;
  logic [CNT_WIDTH-1:0]   r_drop_cnt;

  acq_decim #(.DECIM_WIDTH(DECIM_WIDTH)) u_decim (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_clr),
    .i_valid (i_s_valid),
    .i_decim (r_decim),
    .o_keep  (w_keep)
  );

  // Next-state logic; OR-ing the fill after the release mask makes fill win.
  always_comb begin
    w_state_nxt  = r_state;
    w_active_nxt = r_active;
    w_addr_nxt   = r_addr;
    w_full_nxt   = r_full & ~i_buf_release;
    w_we_nxt     = 2'b00;
    w_latch      = 1'b0;
    w_clr        = 1'b0;
    w_drop       = 1'b0;
    if (i_abort) begin
      w_state_nxt = IDLE;
      w_addr_nxt  = {ADDR_WIDTH{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (i_arm) begin
            w_state_nxt  = ARMED;
            w_latch      = 1'b1;
            w_active_nxt = lowest_free(w_full_nxt);
          end else begin
            w_state_nxt = IDLE;
          end
        end
        ARMED: begin
          w_active_nxt = lowest_free(w_full_nxt);
          if (i_trig) begin
            w_clr       = 1'b1;
            w_state_nxt = (&w_full_nxt) ? WAIT : CAPTURE;
          end else begin
            w_state_nxt = ARMED;
          end
        end
        CAPTURE: begin
          if (w_keep) begin
            w_we_nxt = r_active ? 2'b10 : 2'b01;
            if (r_addr == r_len) begin
              w_full_nxt[r_active] = 1'b1;
              w_active_nxt         = ~r_active;
              w_addr_nxt           = {ADDR_WIDTH{1'b0}};
              if (!r_cont) begin
                w_state_nxt = IDLE;
              end else if (w_full_nxt[~r_active]) begin
                w_state_nxt = WAIT;
              end else begin
                w_state_nxt = CAPTURE;
              end
            end else begin
              w_addr_nxt = r_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
          end else begin
            w_state_nxt = CAPTURE;
          end
        end
        WAIT: begin
          w_drop = w_keep;
          if (i_buf_release[r_active]) begin
            w_state_nxt = CAPTURE;
          end else begin
            w_state_nxt = WAIT;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State, buffer tracking, write stage and statistics registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_active   <= 1'b0;
      r_addr     <= {ADDR_WIDTH{1'b0}};
      r_full     <= 2'b00;
      r_len      <= {ADDR_WIDTH{1'b0}};
      r_decim    <= {DECIM_WIDTH{1'b0}};
      r_cont     <= 1'b0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_we       <= 2'b00;
      r_wr_addr  <= {ADDR_WIDTH{1'b0}};
      r_din      <= {DATA_WIDTH{1'b0}};
      r_overflow <= 1'b0;
      r_drop_cnt <= {CNT_WIDTH{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_active <= w_active_nxt;
      r_addr   <= w_addr_nxt;
      r_full   <= w_full_nxt;
      r_ready  <= 1'b1;
      r_busy   <= (w_state_nxt != IDLE);
      r_we     <= w_we_nxt;
      if (w_we_nxt != 2'b00) begin
        r_wr_addr <= r_addr;
        r_din     <= i_s_data;
      end
      if (w_latch) begin
        r_len      <= i_len;
        r_decim    <= i_decim;
        r_cont     <= i_cont;
        r_overflow <= 1'b0;
        r_drop_cnt <= {CNT_WIDTH{1'b0}};
      end else if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != {CNT_WIDTH{1'b1}}) begin
          r_drop_cnt <= r_drop_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign o_s_ready    = r_ready;
  assign o_bram_we    = r_we;
  assign o_bram_addr  = r_wr_addr;
  assign o_bram_din   = r_din;
  assign o_buf_full   = r_full;
  assign o_active_buf = r_active;
  assign o_busy       = r_busy;
  assign o_overflow   = r_overflow;
  assign o_drop_cnt   = r_drop_cnt;

endmodule
